// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 command transmitter. It inhibits the bus, issues a
//   request-to-send and then shifts one command byte (LSB first, odd parity,
//   stop bit) out on the device-generated clock. It samples the device ACK
//   and waits for the bus to return to idle.
//
//   Optional feature macro: PS2_TX_ACK_CHECK_EN
//     defined   : a sampled ACK of 1 (no ACK) reports oError at oDone
//     undefined : the ACK value is ignored; oError reports timeouts only
//
// Ports
//   iCLK      system clock; all logic runs on its rising edge
//   iRST_n    asynchronous active-low reset
//   iData     command byte, captured when iSend is accepted in IDLE
//   iSend     send request; sampled only while idle
//   iPS2_CLK  PS/2 clock line as read from the pad
//   iPS2_DAT  PS/2 data line as read from the pad
//   oClkOE    1 = pull the PS/2 clock low, 0 = release it
//   oDatOE    1 = pull the PS/2 data low, 0 = release it
//   oBusy     a transaction is in progress
//   oDone     one-cycle pulse at the end of every transaction
//   oError    valid with oDone and held until the next accepted iSend
//
// State table
//   state        | meaning
//   ST_IDLE      | lines released, waiting for iSend
//   ST_INHIBIT   | clock held low for INHIBIT_CYCLES
//   ST_RTS       | clock and data held low (start bit) for RTS_CYCLES
//   ST_BITS      | clock released; data, parity and stop on device falls 1-10
//   ST_ACK       | waiting for device fall 11 to sample the ACK bit
//   ST_WAIT_IDLE | waiting for clock and data both high before finishing

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 16,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oClkOE,
  output logic       oDatOE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int MAX_SEQ = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_TO  = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int CNT_MAX = (MAX_SEQ > MAX_TO) ? MAX_SEQ : MAX_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  // One down-counter serves every phase; each phase loads (length - 1) and
  // finishes on the cycle the counter reads zero.
  localparam cnt_t INHIBIT_LOAD = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t RTS_LOAD     = cnt_t'(RTS_CYCLES - 1);
  localparam cnt_t START_LOAD   = cnt_t'(START_TIMEOUT - 1);
  localparam cnt_t FRAME_LOAD   = cnt_t'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  // Synchronizers. They reset to 1, the idle level of the open-drain bus.
  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;
  logic clk_fall;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= iPS2_CLK;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= iPS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

  state_t     state_q, state_nxt;
  cnt_t       cnt_q, cnt_nxt;
  logic [3:0] edge_q, edge_nxt;
  logic [7:0] data_q, data_nxt;
  logic       parity_q, parity_nxt;
  logic       clk_oe_q, clk_oe_nxt;
  logic       dat_oe_q, dat_oe_nxt;
  logic       drive_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic       error_q, error_nxt;
  logic       abort;
`ifdef PS2_TX_ACK_CHECK_EN
  logic       ack_q, ack_nxt;
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      edge_q   <= edge_nxt;
      data_q   <= data_nxt;
      parity_q <= parity_nxt;
      clk_oe_q <= clk_oe_nxt;
      dat_oe_q <= dat_oe_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      error_q  <= error_nxt;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q    <= ack_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    edge_nxt   = edge_q;
    data_nxt   = data_q;
    parity_nxt = parity_q;
    drive_nxt  = dat_oe_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    error_nxt  = error_q;
    abort      = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_nxt    = ack_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (iSend) begin
          data_nxt   = iData;
          parity_nxt = ~^iData;
          error_nxt  = 1'b0;
          busy_nxt   = 1'b1;
          cnt_nxt    = INHIBIT_LOAD;
          edge_nxt   = '0;
          state_nxt  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          cnt_nxt   = RTS_LOAD;
          state_nxt = ST_RTS;
        end else begin
          cnt_nxt = cnt_q - cnt_t'(1);
        end
      end

      ST_RTS: begin
        if (cnt_q == '0) begin
          // Keep data low as the start bit until the device's first fall.
          cnt_nxt   = START_LOAD;
          drive_nxt = 1'b1;
          state_nxt = ST_BITS;
        end else begin
          cnt_nxt = cnt_q - cnt_t'(1);
        end
      end

      ST_BITS: begin
        // A first fall on the last start-window cycle still counts as in time.
        if (clk_fall && (edge_q == 4'd0)) begin
          cnt_nxt   = FRAME_LOAD;
          edge_nxt  = 4'd1;
          drive_nxt = ~data_q[0];
        end else if (cnt_q == '0) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_q - cnt_t'(1);
          if (clk_fall) begin
            edge_nxt = edge_q + 4'd1;
            if (edge_q < 4'd8) begin
              drive_nxt = ~data_q[edge_q[2:0]];
            end else if (edge_q == 4'd8) begin
              drive_nxt = ~parity_q;
            end else begin
              drive_nxt = 1'b0;
              state_nxt = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        if (cnt_q == '0) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_q - cnt_t'(1);
          if (clk_fall) begin
            edge_nxt  = 4'd11;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_nxt   = dat_sync;
`endif
            state_nxt = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          edge_nxt  = '0;
`ifdef PS2_TX_ACK_CHECK_EN
          error_nxt = ack_q;
`endif
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      edge_nxt  = '0;
      drive_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      error_nxt = 1'b1;
    end

    // Pad enables are registered from the next state so they never glitch.
    clk_oe_nxt = (state_nxt == ST_INHIBIT) || (state_nxt == ST_RTS);
    dat_oe_nxt = (state_nxt == ST_RTS) || ((state_nxt == ST_BITS) && drive_nxt);
  end

  assign oClkOE = clk_oe_q;
  assign oDatOE = dat_oe_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oError = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Bench for ps2_host_tx with a small PS/2 device model (40-cycle clock,
//   configurable ACK) on a wired-AND bus. A transaction-level model tracks
//   the cycles since acceptance and checks the outputs every cycle; the
//   device checks the frame it received.

module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 4;
  localparam int STO = 200;
  localparam int FTO = 2000;

`ifdef PS2_TX_ACK_CHECK_EN
  localparam logic ACK1_ERR = 1'b1;
`else
  localparam logic ACK1_ERR = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       send;
  logic       clk_oe, dat_oe, busy, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk, ps2_dat;

  assign ps2_clk = ~(clk_oe | dev_clk_low);
  assign ps2_dat = ~(dat_oe | dev_dat_low);

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .START_TIMEOUT (STO),
    .FRAME_TIMEOUT (FTO)
  ) dut (
    .iCLK    (CLOCK_50),
    .iRST_n  (rst_n),
    .iData   (data),
    .iSend   (send),
    .iPS2_CLK(ps2_clk),
    .iPS2_DAT(ps2_dat),
    .oClkOE  (clk_oe),
    .oDatOE  (dat_oe),
    .oBusy   (busy),
    .oDone   (done),
    .oError  (err)
  );

  int   checks = 0;
  int   errors = 0;
  bit   mdl_active = 1'b0;
  int   mdl_k = 0;
  bit   mdl_timeout_exp = 1'b0;
  logic mdl_err_exp = 1'b0;
  logic mdl_err_hold = 1'b0;
  int   done_cnt = 0;
  int   dev_fall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as seen on the data line at device rising edges: D0..D7, parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  // Transaction model: k counts rising edges since the accepting edge.
  initial begin
    forever begin
      @(posedge CLOCK_50);
      if (!rst_n) begin
        mdl_active   = 1'b0;
        mdl_err_hold = 1'b0;
      end else if (mdl_active) begin
        mdl_k++;
      end else if (send) begin
        mdl_active = 1'b1;
        mdl_k      = 1;
      end
      @(negedge CLOCK_50);
      if (rst_n) begin
        if (!mdl_active) begin
          check("idle", {busy, clk_oe, dat_oe, done, err}, {4'b0000, mdl_err_hold});
        end else if (mdl_k <= INH) begin
          check("inhibit", {busy, clk_oe, dat_oe, done, err}, 5'b11000);
        end else if (mdl_k <= INH + RTS) begin
          check("rts", {busy, clk_oe, dat_oe, done, err}, 5'b11100);
        end else if (done) begin
          done_cnt++;
          check("done_lines", {busy, clk_oe, dat_oe}, 3'b000);
          check("done_error", err, mdl_err_exp);
          // 20 inhibit + 4 rts + 200 timeout cycles after the accepting edge
          if (mdl_timeout_exp) check("timeout_cycle", mdl_k, 225);
          mdl_err_hold = mdl_err_exp;
          mdl_active   = 1'b0;
        end else begin
          check("frame_phase", {busy, clk_oe, err}, 3'b100);
        end
      end
    end
  end

  task automatic device_run(input bit ack_one, output logic [9:0] got);
    int n;
    n   = 0;
    got = '0;
    while (!(ps2_clk == 1'b1 && ps2_dat == 1'b0) && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL device_request: no request-to-send seen within %0d cycles", n);
      return;
    end
    repeat (10) @(negedge CLOCK_50);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      dev_fall_cnt++;
      repeat (20) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      if (i <= 10) got[i-1] = ps2_dat;
      if (i == 10) begin
        repeat (10) @(negedge CLOCK_50);
        dev_dat_low = ~ack_one;
        repeat (10) @(negedge CLOCK_50);
      end else if (i == 11) begin
        dev_dat_low = 1'b0;
      end else begin
        repeat (20) @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic wait_done(input int base, input int limit);
    int n;
    n = 0;
    while (done_cnt == base && n < limit) begin
      @(posedge CLOCK_50);
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no oDone within %0d cycles", limit);
    end
  endtask

  task automatic run_txn(input string name, input logic [7:0] d, input bit ack_one,
                         input logic exp_err, input logic [9:0] exp_frame);
    logic [9:0] got;
    int base;
    base        = done_cnt;
    mdl_err_exp = exp_err;
    @(negedge CLOCK_50);
    data = d;
    send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
    data = ~d;
    device_run(ack_one, got);
    wait_done(base, 100);
    check({name, "_frame"}, got, exp_frame);
    repeat (30) @(posedge CLOCK_50);
    check({name, "_done_count"}, done_cnt, base + 1);
  endtask

  initial begin
    logic [9:0] got;
    int base;
    rst_n = 1'b0;
    send  = 1'b0;
    data  = 8'h00;
    #1;
    check("reset_async", {clk_oe, dat_oe, busy, done, err}, 5'b00000);
    repeat (3) @(negedge CLOCK_50);
    check("reset_state", {clk_oe, dat_oe, busy, done, err}, 5'b00000);
    #3 rst_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    run_txn("send_ed", 8'hED, 1'b0, 1'b0, 10'h3ED);
    run_txn("send_01", 8'h01, 1'b0, 1'b0, 10'h201);
    run_txn("send_00", 8'h00, 1'b0, 1'b0, 10'h300);
    run_txn("send_ff", 8'hFF, 1'b0, 1'b0, frame_of(8'hFF));
    run_txn("send_a5", 8'hA5, 1'b0, 1'b0, frame_of(8'hA5));
    run_txn("ack_one", 8'hF4, 1'b1, ACK1_ERR, frame_of(8'hF4));

    // Device never clocks: start timeout.
    base            = done_cnt;
    mdl_err_exp     = 1'b1;
    mdl_timeout_exp = 1'b1;
    @(negedge CLOCK_50);
    data = 8'hA5;
    send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
    wait_done(base, 400);
    repeat (20) @(posedge CLOCK_50);
    mdl_timeout_exp = 1'b0;
    check("timeout_done_count", done_cnt, base + 1);

    // Second request during BITS must be ignored.
    base        = done_cnt;
    mdl_err_exp = 1'b0;
    @(negedge CLOCK_50);
    data = 8'hC3;
    send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
    fork
      device_run(1'b0, got);
      begin : extra_send
        repeat (150) @(negedge CLOCK_50);
        data = 8'h55;
        send = 1'b1;
        @(negedge CLOCK_50);
        send = 1'b0;
      end
    join
    wait_done(base, 100);
    check("busy_send_frame", got, frame_of(8'hC3));
    repeat (60) @(posedge CLOCK_50);
    check("busy_send_done_count", done_cnt, base + 1);

    // iSend held high: back-to-back transactions.
    base        = done_cnt;
    mdl_err_exp = 1'b0;
    @(negedge CLOCK_50);
    data = 8'h3C;
    send = 1'b1;
    device_run(1'b0, got);
    wait_done(base, 100);
    check("held_first_frame", got, frame_of(8'h3C));
    @(negedge CLOCK_50);
    send = 1'b0;
    data = 8'h00;
    device_run(1'b0, got);
    wait_done(base + 1, 100);
    check("held_second_frame", got, frame_of(8'h3C));
    repeat (30) @(posedge CLOCK_50);
    check("held_done_count", done_cnt, base + 2);

    // Reset during device edge 5.
    base         = done_cnt;
    mdl_err_exp  = 1'b0;
    dev_fall_cnt = 0;
    @(negedge CLOCK_50);
    data = 8'h96;
    send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
    fork
      device_run(1'b0, got);
      begin : mid_reset
        int n;
        n = 0;
        while (dev_fall_cnt < 5 && n < 2000) begin
          @(negedge CLOCK_50);
          n++;
        end
        repeat (3) @(negedge CLOCK_50);
        #3 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {clk_oe, dat_oe, busy, done, err}, 5'b00000);
        repeat (5) @(negedge CLOCK_50);
        #3 rst_n = 1'b1;
      end
    join
    repeat (20) @(posedge CLOCK_50);
    check("mid_reset_no_done", done_cnt, base);

    run_txn("after_reset", 8'h5A, 1'b0, 1'b0, frame_of(8'h5A));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
